text_buffer_writer: RTL and testbench
=====================================

Name: text_buffer_writer

Overview:
- Write side of the 80x60 character text buffer that the VGA text renderer reads.
- Accepts a byte stream of characters over a valid/ready handshake, tracks a cursor, and writes each character into the 32-bit-word text RAM.
- Packing is 4 chars per word: lane = col[1:0], byte 0 = lowest column.
- Interprets a small set of control codes, and clears the screen on reset and on form feed.

Parameters:
- COLS, 80, characters per row; must be a multiple of 4.
- ROWS, 60, rows per screen.
- BASE_ADDR, 0, word address of character (0,0) in the text RAM.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- char_valid  input  1  char_data holds a character.
- char_data  input  8  character/control code.
- char_ready  output  1  block can accept a character this cycle.
- mem_addr  output  32  word address into the text RAM.
- mem_wdata  output  32  write data.
- mem_be  output  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- mem_we  output  1  write strobe, one word per asserted cycle.
- cursor_col  output  7  current column, 0..COLS-1.
- cursor_row  output  6  current row, 0..ROWS-1.
- busy  output  1  high in any non-IDLE state.

Behaviour:
- One clock domain. rst_n is synchronous active-low. While rst_n=0:
  - state=CLEAR, clear counter=0, cursor=(0,0).
  - mem_we=0, char_ready=0, busy=1, mem_be=0, mem_wdata=0, mem_addr=BASE_ADDR.
- Address rule: addr = BASE_ADDR + (row*COLS + col) >> 2. Arithmetic is 32-bit; the row*COLS product is at least 13 bits wide, with no truncation.
- Byte placement: lane = col[1:0]. mem_wdata = char replicated in all 4 bytes; mem_be = 4'b0001 << lane.
- States:
  - CLEAR: each cycle writes word k (k=0..ROWS*COLS/4-1, i.e. 1200 words by default) with wdata=0, be=4'hF, we=1. After the last word, go to IDLE. char_ready=0.
  - IDLE: char_ready=1, busy=0, mem_we=0. On char_valid&&char_ready, decode char_data:
    - 0x20..0x7E: latch the char, go to WRITE.
    - 0x0D (CR): col=0; stay IDLE.
    - 0x0A (LF): col=0, row=row+1 (ROWS-1 wraps to 0); stay IDLE.
    - 0x08 (BS): move cursor back one position. col>0 gives col-1. col=0,row>0 gives (COLS-1,row-1). (0,0) leaves the cursor unchanged. Then latch char 0x00 and go to WRITE, which erases that cell.
    - 0x0C (FF): cursor=(0,0), counter=0, go to CLEAR.
    - Any other code is consumed and ignored; no write.
  - WRITE: one cycle.
    - Outputs: mem_we=1, addr/be/wdata from the current cursor, char_ready=0.
    - Printable char: then advance col. At col=COLS-1, col=0 and row+1, with row wraparound ROWS-1 to 0.
    - BS: no cursor advance.
    - Return to IDLE.
- Throughput: printable chars take 1 per 2 cycles. CR, LF and ignored codes accept back-to-back.
- Latency: a char accepted at cycle N is written at cycle N+1; the cursor update is visible at N+2.
- No scrolling: row wraparound overwrites row 0 in place (see optional feature).
- Reset asserted mid-CLEAR or mid-WRITE: the in-flight operation is abandoned and the full clear restarts after release.
- mem_we is never high in IDLE. char_ready is never high outside IDLE.

Optional Feature:
- Macro: TEXT_ROW_CLEAR_EN.
- Defined:
  - Any cursor advance that changes the row (LF, or end-of-line wrap in WRITE) enters ROWCLR instead of IDLE.
  - ROWCLR writes COLS/4 zero words of the new row (20 by default, be=4'hF), one per cycle, with char_ready=0 and busy=1.
  - Then return to IDLE.
  - BS moving to the previous row does not trigger ROWCLR.
- Undefined: ROWCLR does not exist; new rows retain stale text until overwritten.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Require exactly 1200 writes to addr 0..1199, wdata=0, be=F. Then char_ready=1 and cursor=(0,0).
- Send 'A','B','C','D','E' (0x41..0x45) from (0,0):
  - Writes go to addr 0 with be=1,2,4,8, then addr 1 with be=1; wdata=0x41414141 on the first.
  - Final cursor=(5,0). Each write occurs 1 cycle after its accept.
- Cursor (79,2), send 'Z':
  - Write addr (2*80+79)>>2=59, be=8.
  - Cursor becomes (0,3), or (0,3) after 20 zero writes to addr 60..79 with TEXT_ROW_CLEAR_EN.
- Cursor (0,59), send LF: cursor=(0,0). With TEXT_ROW_CLEAR_EN, addr 0..19 are cleared.
- BS cases:
  - BS at (0,1): cursor=(79,0); write addr 19, be=8, wdata=0.
  - BS at (0,0): write addr 0, be=1, wdata=0; cursor unchanged.
- Send FF mid-screen, then assert rst_n=0 at clear word 500 for 1 cycle. Require the clear to restart at addr 0 and complete all 1200 words.

Source files
------------

// File: rtl/text_buffer_writer.sv
// text_buffer_writer: cursor-tracking character writer into a 4-chars-per-word text RAM.
// Optional feature: define TEXT_ROW_CLEAR_EN to zero every newly entered row (ROWCLR state).
module text_buffer_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 60,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);
  localparam int WORDS = ROWS * COLS / 4;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] CLR_LAST = CW'(WORDS - 1);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
`ifdef TEXT_ROW_CLEAR_EN
  localparam logic [CW-1:0] ROW_LAST = CW'(COLS / 4 - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, ROWCLR} state_t;
  localparam state_t NEWROW = ROWCLR;
`else
  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;
  localparam state_t NEWROW = IDLE;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] col_q, col_d;
  logic [5:0] row_q, row_d;
  logic [7:0] char_q, char_d;
  logic [31:0] lin, cur_addr;
  logic [5:0] row_inc;
  assign lin = 32'(row_q) * 32'(COLS) + 32'(col_q);
  assign cur_addr = BASE_ADDR + (lin >> 2);
  assign row_inc = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  // State, clear counter, cursor and latched character registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      col_q <= '0;
      row_q <= '0;
      char_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      row_q <= row_d;
      char_q <= char_d;
    end
  end
  // Next-state decode and RAM/handshake outputs; everything is held quiet while in reset.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    row_d = row_q;
    char_d = char_q;
    char_ready = 1'b0;
    mem_we = 1'b0;
    mem_be = 4'h0;
    mem_wdata = 32'h0;
    mem_addr = BASE_ADDR;
    busy = 1'b1;
    if (rst_n) begin
      case (state_q)
        CLEAR: begin
          mem_we = 1'b1;
          mem_be = 4'hF;
          mem_addr = BASE_ADDR + 32'(cnt_q);
          cnt_d = (cnt_q == CLR_LAST) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == CLR_LAST) ? IDLE : CLEAR;
        end
        IDLE: begin
          char_ready = 1'b1;
          busy = 1'b0;
          if (char_valid) begin
            if (char_data >= 8'h20 && char_data <= 8'h7E) begin
              char_d = char_data;
              state_d = WRITE;
            end else if (char_data == 8'h0D) begin
              col_d = '0;
            end else if (char_data == 8'h0A) begin
              col_d = '0;
              row_d = row_inc;
              state_d = NEWROW;
            end else if (char_data == 8'h08) begin
              col_d = (col_q != '0) ? col_q - 1'b1 : (row_q != '0) ? COL_LAST : col_q;
              row_d = (col_q == '0 && row_q != '0) ? row_q - 1'b1 : row_q;
              char_d = 8'h00;
              state_d = WRITE;
            end else if (char_data == 8'h0C) begin
              col_d = '0;
              row_d = '0;
              cnt_d = '0;
              state_d = CLEAR;
            end
          end
        end
        WRITE: begin
          mem_we = 1'b1;
          mem_be = 4'b0001 << col_q[1:0];
          mem_wdata = {4{char_q}};
          mem_addr = cur_addr;
          state_d = IDLE;
          // A latched 0x00 marks a backspace erase, which leaves the cursor in place.
          if (char_q != 8'h00) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            row_d = (col_q == COL_LAST) ? row_inc : row_q;
            state_d = (col_q == COL_LAST) ? NEWROW : IDLE;
          end
        end
`ifdef TEXT_ROW_CLEAR_EN
        ROWCLR: begin
          mem_we = 1'b1;
          mem_be = 4'hF;
          mem_addr = cur_addr + 32'(cnt_q);
          cnt_d = (cnt_q == ROW_LAST) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == ROW_LAST) ? IDLE : ROWCLR;
        end
`endif
        default: state_d = CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_text_buffer_writer.sv
// tb_text_buffer_writer: scoreboard bench for text_buffer_writer with a cursor/screen reference model.
module tb_text_buffer_writer;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam logic [31:0] BASE = 32'd0;
  localparam int WORDS = ROWS * COLS / 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic char_ready, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  int cyc = 0;
  int nchecks = 0;
  int npass = 0;
  int m_col = 0;
  int m_row = 0;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t sb[$];

  text_buffer_writer #(.COLS(COLS), .ROWS(ROWS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    nchecks++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input int c);
    wr_t e;
    e.addr = a;
    e.be = be;
    e.data = d;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push_clear();
    for (int k = 0; k < WORDS; k++) push_wr(BASE + 32'(k), 4'hF, 32'h0, -1);
  endtask

  task automatic push_char(input logic [7:0] c, input int wc);
    int lin;
    lin = m_row * COLS + m_col;
    push_wr(BASE + 32'(lin / 4), 4'(1 << (m_col % 4)), {4{c}}, wc);
  endtask

  task automatic new_row();
    m_row = (m_row + 1) % ROWS;
`ifdef TEXT_ROW_CLEAR_EN
    for (int k = 0; k < COLS / 4; k++) push_wr(BASE + 32'(m_row * COLS / 4 + k), 4'hF, 32'h0, -1);
`endif
  endtask

  task automatic model_accept(input logic [7:0] c, input int ac);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_char(c, ac + 1);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        new_row();
      end
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h0A) begin
      m_col = 0;
      new_row();
    end else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
      else if (m_row > 0) begin
        m_col = COLS - 1;
        m_row--;
      end
      push_char(8'h00, ac + 1);
    end else if (c == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      push_clear();
    end
  endtask

  // Called and returns just after a rising edge.
  task automatic send(input logic [7:0] c);
    int n = 0;
    char_valid = 1'b1;
    char_data = c;
    @(negedge clk);
    while (!char_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) chk("accept_timeout", 96'(char_ready), 96'(1));
    else model_accept(c, cyc);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, 96'(busy), 96'(0));
    chk({nm, "_state"}, {char_ready, cursor_col, cursor_row, 32'(sb.size())},
        {1'b1, 7'(m_col), 6'(m_row), 32'd0});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sb.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    m_col = 0;
    m_row = 0;
    chk("reset_cursor", {cursor_col, cursor_row}, 96'(0));
    rst_n = 1'b1;
    push_clear();
  endtask

  // Monitor: reset-time outputs, and every RAM write against the scoreboard front.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {mem_we, char_ready, busy, mem_be, mem_wdata, mem_addr},
          {1'b0, 1'b0, 1'b1, 4'h0, 32'h0, BASE});
    end else if (mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_be, 28'h0, mem_wdata}, 96'(0));
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write", {char_ready, mem_addr, mem_be, 27'h0, mem_wdata},
            {1'b0, e.addr, e.be, 27'h0, e.data});
        if (e.cyc >= 0) chk("write_latency", 96'(cyc), 96'(e.cyc));
      end
    end
  end

  initial begin
    logic [7:0] ign [6];
    ign = '{8'h00, 8'h1B, 8'h7F, 8'h80, 8'hFF, 8'h09};
    do_reset(3);
    wait_idle("post_reset");
    for (int i = 0; i < 5; i++) send(8'h41 + 8'(i));
    wait_idle("abcde");
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'($urandom_range(8'h20, 8'h7E)));
    wait_idle("at_79_2");
    send(8'h5A);
    wait_idle("eol_wrap");
    for (int i = 0; i < 56; i++) send(8'h0A);
    wait_idle("at_row59");
    send(8'h0A);
    wait_idle("lf_row_wrap");
    send(8'h0A);
    send(8'h08);
    wait_idle("bs_row_back");
    send(8'h0D);
    send(8'h08);
    wait_idle("bs_origin");
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 9);
      c = (r <= 5) ? 8'($urandom_range(8'h20, 8'h7E)) : (r == 6) ? 8'h0D : (r == 7) ? 8'h0A :
          (r == 8) ? 8'h08 : ign[$urandom_range(0, 5)];
      send(c);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle("random");
    send(8'h48);
    send(8'h49);
    send(8'h0C);
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    chk("abandoned_clear_words", 96'(sb.size()), 96'(WORDS - 500));
    do_reset(1);
    wait_idle("clear_restart");
    send(8'h51);
    wait_idle("after_restart");
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end
endmodule
